// File: rtl/isqrt_pkg.sv
// ============================================================
// isqrt_pkg : shared types and width helpers for isqrt_seq
// Rev 1.0
// ============================================================
`default_nettype none

package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int root_w(input int w);
    return w / 2;
  endfunction

  function automatic int rem_w(input int w);
    return w / 2 + 1;
  endfunction

  // One extra bit so the counter can run past zero into a negative sentinel
  function automatic int cnt_w(input int w);
    return $clog2(w / 2) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/isqrt_step.sv
// ============================================================
// isqrt_step : one restoring digit of the square-root recurrence
// Rev 1.0
// ============================================================
`default_nettype none

module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [rem_w(W)-1:0]  rem_in,
  input  logic [root_w(W)-1:0] root_in,
  input  logic [1:0]           bits,
  output logic [rem_w(W)-1:0]  rem_out,
  output logic [root_w(W)-1:0] root_out
);

  localparam int RTW = root_w(W);
  localparam int RMW = rem_w(W);
  localparam int TW  = W / 2 + 3;

  logic [TW-1:0] trial;
  logic [TW-1:0] diff;

  assign trial = {rem_in, bits};
  assign diff  = trial - {1'b0, root_in, 2'b01};

  // diff MSB set means the trial subtraction went negative: restore
  always_comb begin
    root_out    = RTW'({root_in, 1'b0});
    root_out[0] = ~diff[TW-1];
    rem_out     = diff[TW-1] ? RMW'(trial) : RMW'(diff);
  end

endmodule

`default_nettype wire

// File: rtl/isqrt_seq.sv
// ============================================================
// isqrt_seq : sequential integer square root, one root bit per clock
// Rev 1.0
// ============================================================
`default_nettype none

module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enb,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [root_w(W)-1:0] root,
  output logic [rem_w(W)-1:0]  rem,
  output logic                 exact
);

  localparam int RTW = root_w(W);
  localparam int RMW = rem_w(W);
  localparam int CW  = cnt_w(W);

  if (W < 2 || (W % 2) != 0) begin : g_bad_width
    $error("isqrt_seq: W must be even and >= 2");
  end

  state_t           state;
  state_t           state_nx;
  logic             armed;
  logic             accept;
  logic [W-1:0]     sreg;
  logic [RTW-1:0]   part_root;
  logic [RMW-1:0]   part_rem;
  logic [CW-1:0]    cnt;
  logic [RTW-1:0]   step_root;
  logic [RMW-1:0]   step_rem;

  isqrt_step #(.W(W)) u_step (
    .rem_in   (part_rem),
    .root_in  (part_root),
    .bits     (sreg[W-1 -: 2]),
    .rem_out  (step_rem),
    .root_out (step_root)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = enb & armed;
        accept   = in_valid & in_ready;
        if (accept) state_nx = CALC;
      end
      CALC: begin
        if (cnt[CW-1]) state_nx = DONE;
      end
      DONE: begin
        out_valid = enb;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!enb) state_nx = IDLE;
  end

  // Counter runs W/2-1 down to -1; the extra CALC cycle at -1 publishes the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      sreg      <= '0;
      part_root <= '0;
      part_rem  <= '0;
      cnt       <= '0;
      root      <= '0;
      rem       <= '0;
      exact     <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (!enb) begin
        root  <= '0;
        rem   <= '0;
        exact <= 1'b0;
      end else if (state == IDLE) begin
        if (accept) begin
          sreg      <= in;
          part_root <= '0;
          part_rem  <= '0;
          cnt       <= CW'(RTW - 1);
        end
      end else if (state == CALC) begin
        if (!cnt[CW-1]) begin
          sreg      <= sreg << 2;
          part_root <= step_root;
          part_rem  <= step_rem;
          cnt       <= cnt - 1'b1;
        end else begin
          root  <= part_root;
          rem   <= part_rem;
          exact <= (part_rem == '0);
        end
      end
    end
  end

endmodule

`default_nettype wire
